// File: rtl/decade_stream_checker.sv
// rtl/decade_stream_checker.sv - lock/track monitor for a 0-9 decade digit stream with sync
// Optional ErrCount output when ERR_COUNT_EN is defined.
module decade_stream_checker #(
  parameter int LOCK_DECADES = 2,
  parameter int MISS_LIMIT   = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Din,
  input  logic       Qin,
  output logic       Locked,
  output logic       Err,
  output logic [3:0] Expected,
  output logic [7:0] DecadeBcd,
  output logic       Tick
`ifdef ERR_COUNT_EN
  ,
  output logic [7:0] ErrCount
`endif
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t     state, state_d;
  logic [3:0] expected_d;
  logic [3:0] good_cnt, good_cnt_d;
  logic [3:0] miss_cnt, miss_cnt_d;
  logic [7:0] bcd_d;
  logic       err_d, tick_d;
  logic       good, sync0;
  logic [3:0] exp_inc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens, units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  assign good    = (Din == Expected) && (Qin == (Expected == 4'd0));
  assign sync0   = Qin && (Din == 4'd0);
  assign exp_inc = (Expected == 4'd9) ? 4'd0 : Expected + 4'd1;
  assign Locked  = (state == LOCKED);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= HUNT;
      Expected  <= 4'd0;
      good_cnt  <= 4'd0;
      miss_cnt  <= 4'd0;
      DecadeBcd <= 8'h00;
      Err       <= 1'b0;
      Tick      <= 1'b0;
    end else begin
      state     <= state_d;
      Expected  <= expected_d;
      good_cnt  <= good_cnt_d;
      miss_cnt  <= miss_cnt_d;
      DecadeBcd <= bcd_d;
      Err       <= err_d;
      Tick      <= tick_d;
    end
  end

  always_comb begin
    state_d    = state;
    expected_d = Expected;
    good_cnt_d = good_cnt;
    miss_cnt_d = miss_cnt;
    bcd_d      = DecadeBcd;
    err_d      = 1'b0;
    tick_d     = 1'b0;
    case (state)
      HUNT: begin
        if (sync0) begin
          state_d    = TRACK;
          expected_d = 4'd1;
          good_cnt_d = 4'd0;
        end
      end
      TRACK: begin
        if (good) begin
          expected_d = exp_inc;
          if (Expected == 4'd9) begin
            good_cnt_d = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == 4'(LOCK_DECADES)) begin
              state_d    = LOCKED;
              miss_cnt_d = 4'd0;
            end
          end
        end else begin
          err_d = 1'b1;
          if (sync0) begin
            // a sync on the wrong digit is taken as the new decade start
            expected_d = 4'd1;
            good_cnt_d = 4'd0;
          end else begin
            state_d    = HUNT;
            expected_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        expected_d = exp_inc;
        if (good) begin
          miss_cnt_d = 4'd0;
          if (Expected == 4'd9) begin
            tick_d = 1'b1;
            bcd_d  = bcd_inc(DecadeBcd);
          end
        end else begin
          err_d      = 1'b1;
          miss_cnt_d = miss_cnt + 4'd1;
          if (miss_cnt + 4'd1 == 4'(MISS_LIMIT)) begin
            state_d    = HUNT;
            expected_d = 4'd0;
            miss_cnt_d = 4'd0;
          end
        end
      end
      default: begin
        state_d    = HUNT;
        expected_d = 4'd0;
      end
    endcase
  end

`ifdef ERR_COUNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      ErrCount <= 8'h00;
    else if (err_d && ErrCount != 8'hFF)
      ErrCount <= ErrCount + 8'h01;
  end
`endif

endmodule

// File: tb/tb_decade_stream_checker.sv
// tb/tb_decade_stream_checker.sv - directed vector bench for decade_stream_checker
module tb_decade_stream_checker;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Din = 4'd0;
  logic       Qin = 1'b0;
  logic       Locked, Err, Tick;
  logic [3:0] Expected;
  logic [7:0] DecadeBcd;
`ifdef ERR_COUNT_EN
  logic [7:0] ErrCount;
`endif

  int nvec = 0;
  int nmis = 0;

  decade_stream_checker #(.LOCK_DECADES(2), .MISS_LIMIT(3)) dut (
    .Clk(Clk), .Reset(Reset), .Din(Din), .Qin(Qin),
    .Locked(Locked), .Err(Err), .Expected(Expected),
    .DecadeBcd(DecadeBcd), .Tick(Tick)
`ifdef ERR_COUNT_EN
    , .ErrCount(ErrCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0] din;
    logic       qin;
    logic       lk;
    logic       er;
    logic [3:0] ex;
    logic [7:0] bcd;
    logic       tk;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int d, input int q, input int lk, input int er,
                              input int ex, input int bcd, input int tk);
    vec_t v;
    v.din = 4'(d); v.qin = 1'(q); v.lk = 1'(lk); v.er = 1'(er);
    v.ex = 4'(ex); v.bcd = 8'(bcd); v.tk = 1'(tk);
    tbl.push_back(v);
  endfunction

  task automatic step(input logic [3:0] d, input logic q);
    @(negedge Clk);
    Din = d;
    Qin = q;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic lk, input logic er,
                       input logic [3:0] ex, input logic [7:0] bcd, input logic tk);
    nvec++;
    if (Locked !== lk || Err !== er || Expected !== ex || DecadeBcd !== bcd || Tick !== tk) begin
      nmis++;
      $display("FAIL %s: got Locked=%b Err=%b Expected=%0d DecadeBcd=%h Tick=%b, want Locked=%b Err=%b Expected=%0d DecadeBcd=%h Tick=%b",
               tag, Locked, Err, Expected, DecadeBcd, Tick, lk, er, ex, bcd, tk);
    end
  endtask

  initial begin
    int dec;
    // clean stream: lock on the 2nd nine, first Tick on the 3rd
    for (int i = 0; i < 30; i++)
      add(i % 10, (i % 10) == 0, i >= 19, 0, (i + 1) % 10, (i == 29) ? 1 : 0, i == 29);
    // one bad digit while locked
    add(0, 1, 1, 0, 1, 1, 0);
    add(1, 0, 1, 0, 2, 1, 0);
    add(2, 0, 1, 0, 3, 1, 0);
    add(3, 0, 1, 0, 4, 1, 0);
    add(5, 0, 1, 1, 5, 1, 0);
    add(5, 0, 1, 0, 6, 1, 0);
    add(6, 0, 1, 0, 7, 1, 0);
    add(7, 0, 1, 0, 8, 1, 0);
    add(8, 0, 1, 0, 9, 1, 0);
    add(9, 0, 1, 0, 0, 2, 1);
    // two misses, a good sample clears the count, two more misses keep lock
    add(0, 1, 1, 0, 1, 2, 0);
    add(7, 0, 1, 1, 2, 2, 0);
    add(7, 0, 1, 1, 3, 2, 0);
    add(3, 0, 1, 0, 4, 2, 0);
    add(9, 0, 1, 1, 5, 2, 0);
    add(9, 0, 1, 1, 6, 2, 0);
    add(6, 0, 1, 0, 7, 2, 0);
    add(7, 0, 1, 0, 8, 2, 0);
    add(8, 0, 1, 0, 9, 2, 0);
    add(9, 0, 1, 0, 0, 3, 1);
    // three misses: missing sync, sync on 1, digit > 9 -> HUNT
    add(0, 0, 1, 1, 1, 3, 0);
    add(1, 1, 1, 1, 2, 3, 0);
    add(12, 0, 0, 1, 0, 3, 0);
    add(5, 0, 0, 0, 0, 3, 0);
    // resync in TRACK at expected 6, lock two decades later
    add(0, 1, 0, 0, 1, 3, 0);
    for (int d = 1; d <= 5; d++) add(d, 0, 0, 0, d + 1, 3, 0);
    add(0, 1, 0, 1, 1, 3, 0);
    for (int d = 1; d <= 9; d++) add(d, 0, 0, 0, (d + 1) % 10, 3, 0);
    for (int d = 0; d <= 9; d++) add(d, d == 0, d == 9, 0, (d + 1) % 10, 3, 0);
    for (int d = 0; d <= 9; d++) add(d, d == 0, 1, 0, (d + 1) % 10, (d == 9) ? 4 : 3, d == 9);

    #12;
    check("reset_hold", 0, 0, 0, 8'h00, 0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].din, tbl[i].qin);
      check($sformatf("vec%0d", i), tbl[i].lk, tbl[i].er, tbl[i].ex, tbl[i].bcd, tbl[i].tk);
    end
`ifdef ERR_COUNT_EN
    nvec++;
    if (ErrCount !== 8'd9) begin
      nmis++;
      $display("FAIL errcount_table: got %0d want 9", ErrCount);
    end
`endif

    // run through 09->10 and 99->00
    dec = 4;
    for (int k = 0; k < 96; k++) begin
      for (int d = 0; d <= 9; d++) begin
        if (d == 9) dec = (dec + 1) % 100;
        step(4'(d), d == 0);
        check($sformatf("wrap_dec%0d_d%0d", k, d), 1, 0, 4'((d + 1) % 10),
              {4'(dec / 10), 4'(dec % 10)}, d == 9);
      end
    end

    // asynchronous reset mid-decade
    for (int d = 0; d <= 4; d++) step(4'(d), d == 0);
    #2;
    Reset = 1'b1;
    #1;
    check("async_reset", 0, 0, 0, 8'h00, 0);
`ifdef ERR_COUNT_EN
    nvec++;
    if (ErrCount !== 8'd0) begin
      nmis++;
      $display("FAIL errcount_reset: got %0d want 0", ErrCount);
    end
`endif
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(4'(i % 10), (i % 10) == 0);
      check($sformatf("relock%0d", i), i == 19, 0, 4'((i + 1) % 10), 8'h00, 0);
    end

`ifdef ERR_COUNT_EN
    // repeated sync while tracking: every sample after the first is a resync error
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 301; i++) step(4'd0, 1'b1);
    nvec++;
    if (ErrCount !== 8'hFF) begin
      nmis++;
      $display("FAIL errcount_sat: got %h want ff", ErrCount);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
